timer_dev: RTL

Memory-mapped 32-bit countdown timer that responds to the data-memory-side store/load bus driven by the M stage. The M stage is the initiator: it presents a word select, write data and a write enable. The timer answers reads combinationally and raises an interrupt request toward the CP0/exception logic when its count expires. Address decoding to the timer's base is done outside this block.

---
 rtl/timer_dev_pkg.sv | 28 ++
 rtl/timer_dev.sv | 106 ++++++++++
 2 files changed

// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: word selects, CTRL
// bit layout, mode codes and FSM state encodings.
package timer_dev_pkg;

  // Word select (address bits [3:2])
  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  // CTRL bit positions; only the low CtrlW bits are implemented
  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlModeLo = 1;
  localparam int unsigned CtrlModeHi = 2;
  localparam int unsigned CtrlIm     = 3;
  localparam int unsigned CtrlW      = 4;

  // Mode codes; anything other than reload behaves as one-shot
  localparam logic [1:0] ModeOneShot = 2'd0;
  localparam logic [1:0] ModeReload  = 2'd1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// 32-bit countdown timer on the M-stage load/store bus. Three words (CTRL,
// PRESET, COUNT), combinational read data and a masked interrupt request.
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  state_e           state_q, state_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  logic [31:0]      preset_q, preset_d;
  logic [31:0]      count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic en, reload, ctrl_we, preset_we;

  assign en        = ctrl_q[CtrlEn];
  assign reload    = (ctrl_q[CtrlModeHi:CtrlModeLo] == ModeReload);
  assign ctrl_we   = WE && (A == AddrCtrl);
  assign preset_we = WE && (A == AddrPreset);

  // Next-state: FSM first, then bus writes so a CTRL write overrides the
  // one-shot Enable clear and any irq_flag update on the same edge.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      StIdle: begin
        if (en) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Covers PRESET = 0 too: never wraps below zero
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        if (reload) begin
          irq_flag_d = 1'b0;
          state_d    = StLoad;
        end else begin
          ctrl_d[CtrlEn] = 1'b0;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ctrl_we) begin
      ctrl_d     = WD[CtrlW-1:0];
      irq_flag_d = 1'b0;
    end
    if (preset_we) preset_d = WD;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Zero-latency read mux; unused word reads as zero
  always_comb begin
    RD = '0;
    case (A)
      AddrCtrl:   RD = {{(32 - CtrlW){1'b0}}, ctrl_q};
      AddrPreset: RD = preset_q;
      AddrCount:  RD = count_q;
      default:    RD = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[CtrlIm];

endmodule
